// File: rtl/spp_maxpool_stream.sv
// Streaming same-size KSIZE x KSIZE max-pool over an H x W raster frame.
// Separable max: horizontal shift register, then line buffers for vertical.
module spp_maxpool_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int CH         = 1,
  parameter int H          = 8,
  parameter int W          = 8,
  parameter int KSIZE      = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CH*DATA_WIDTH-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CH*DATA_WIDTH-1:0] out_data,
  output logic                     out_first,
  output logic                     out_last,
  output logic                     busy
);

  localparam int P  = (KSIZE - 1) / 2;
  localparam int NR = H + P;
  localparam int NC = W + P;
  localparam int RW = $clog2(NR + 1);
  localparam int CW = $clog2(NC + 1);
  localparam int IW = (W > 1) ? $clog2(W) : 1;
  localparam int NL = (KSIZE > 1) ? KSIZE - 1 : 1;

  localparam logic [DATA_WIDTH-1:0] PAD =
    {1'b1, {(DATA_WIDTH-1){1'b0}}};

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACTIVE  = 2'd1;
  localparam logic [1:0] S_PAD_COL = 2'd2;
  localparam logic [1:0] S_PAD_ROW = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic [RW-1:0] vr;
  logic [RW-1:0] vr_nx;
  logic [CW-1:0] vc;
  logic [CW-1:0] vc_nx;
  logic          is_real;
  logic          slot_free;
  logic          adv;
  logic          produce;
  logic          col_ok;
  logic          row_end;
  logic          frame_end;
  logic [IW-1:0] col;

  logic [CH*DATA_WIDTH-1:0] pool;

  function automatic logic [DATA_WIDTH-1:0] smax(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  assign is_real   = (vr < RW'(H)) && (vc < CW'(W));
  assign slot_free = !out_valid || out_ready;
  assign col_ok    = vc >= CW'(P);
  assign produce   = (vr >= RW'(P)) && col_ok;
  assign row_end   = vc == CW'(NC - 1);
  assign frame_end = row_end && (vr == RW'(NR - 1));
  assign col       = IW'(vc - CW'(P));

  assign in_ready = slot_free && !reset && is_real &&
                    (state == S_IDLE || state == S_ACTIVE);

  // Padding positions never take input; they run on output space alone.
  assign adv = is_real ? (in_valid && in_ready)
                       : (slot_free && state != S_IDLE);

  assign busy = (state != S_IDLE) || out_valid;

  always_comb begin
    vc_nx = row_end ? '0 : vc + CW'(1);
    vr_nx = vr;
    if (row_end) begin
      vr_nx = frame_end ? '0 : vr + RW'(1);
    end
    if (frame_end) begin
      state_nx = S_IDLE;
    end else if (vr_nx >= RW'(H)) begin
      state_nx = S_PAD_ROW;
    end else if (vc_nx >= CW'(W)) begin
      state_nx = S_PAD_COL;
    end else begin
      state_nx = S_ACTIVE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      vr    <= '0;
      vc    <= '0;
    end else if (adv) begin
      state <= state_nx;
      vr    <= vr_nx;
      vc    <= vc_nx;
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_ch
    logic [DATA_WIDTH-1:0] x;

    assign x = is_real ? in_data[k*DATA_WIDTH +: DATA_WIDTH] : PAD;

    if (KSIZE > 1) begin : g_win
      logic [DATA_WIDTH-1:0] hsr [NL];
      logic [DATA_WIDTH-1:0] lb  [NL][W];
      logic [DATA_WIDTH-1:0] hcur;
      logic [DATA_WIDTH-1:0] vcur;

      // Stale samples from the previous row, previous frame or
      // before reset are excluded by the counter-derived masks.
      always_comb begin
        hcur = x;
        for (int d = 1; d < KSIZE; d++) begin
          if (int'(vc) >= d) hcur = smax(hcur, hsr[d-1]);
        end
        vcur = hcur;
        for (int i = 0; i < KSIZE - 1; i++) begin
          if (int'(vr) > i) vcur = smax(vcur, lb[i][col]);
        end
      end

      always_ff @(posedge clk) begin
        if (adv) begin
          hsr[0] <= x;
          for (int d = 1; d < KSIZE - 1; d++) begin
            hsr[d] <= hsr[d-1];
          end
          if (col_ok) begin
            lb[0][col] <= hcur;
            for (int i = 1; i < KSIZE - 1; i++) begin
              lb[i][col] <= lb[i-1][col];
            end
          end
        end
      end

      assign pool[k*DATA_WIDTH +: DATA_WIDTH] = vcur;
    end else begin : g_pass
      assign pool[k*DATA_WIDTH +: DATA_WIDTH] = x;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (adv && produce) begin
      out_valid <= 1'b1;
      out_first <= (vr == RW'(P)) && (vc == CW'(P));
      out_last  <= frame_end;
      out_data  <= pool;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule
